// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the stage-3 memory access controller: load/store size
// codes and the access FSM state type.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE     = 2'b00;
    localparam logic [1:0] SIZE_HALF     = 2'b01;
    localparam logic [1:0] SIZE_WORD     = 2'b10;
    localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_RSP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load lane extraction: picks the byte/half lane addressed by
// addr_lo from the bus word and zero- or sign-extends it to 32 bits.
module load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SIZE_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Stage-3 load/store data-bus controller (IDLE -> REQ -> WAIT_RSP).
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        req_valid_in,
    input  logic        is_store_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,
    output logic        ready_out,
    output logic        stall_out,
    output logic        dbus_req_out,
    output logic        dbus_we_out,
    output logic [31:0] dbus_addr_out,
    output logic [31:0] dbus_wdata_out,
    output logic [3:0]  dbus_be_out,
    input  logic        dbus_gnt_in,
    input  logic        dbus_rvalid_in,
    input  logic [31:0] dbus_rdata_in,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  load_rd_addr_out,
    output logic        misalign_trap_out
);

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction
`endif

    state_t      state_q, state_d;
    logic        accept;
    logic        trap_hit;
    logic        in_req;
    logic        rsp_take;

    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;
    logic        we_p0;
    logic [1:0]  size_p0;
    logic        uns_p0;
    logic [4:0]  rd_p0;

    logic        vld_p1;
    logic [31:0] load_data_p1;
    logic [4:0]  load_rd_p1;
    logic        trap_p1;
    logic [31:0] aligned;

    assign accept = (state_q == IDLE) && req_valid_in;
`ifdef MISALIGN_TRAP_EN
    assign trap_hit = accept && is_misaligned(load_size_in, addr_in[1:0]);
`else
    assign trap_hit = 1'b0;
`endif
    assign in_req   = (state_q == REQ);
    assign rsp_take = (state_q == WAIT_RSP) && dbus_rvalid_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rvalid is deliberately not examined in REQ, even alongside the grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && !trap_hit) state_d = REQ;
            REQ:      if (dbus_gnt_in) state_d = we_p0 ? IDLE : WAIT_RSP;
            WAIT_RSP: if (dbus_rvalid_in) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Stage p0: operation latched at accept, held for the bus request
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            addr_p0  <= '0;
            wdata_p0 <= '0;
            be_p0    <= '0;
            we_p0    <= 1'b0;
            size_p0  <= '0;
            uns_p0   <= 1'b0;
            rd_p0    <= '0;
        end else if (accept) begin
            addr_p0  <= addr_in;
            wdata_p0 <= lane_replicate(load_size_in, store_data_in);
            be_p0    <= lane_enables(load_size_in, addr_in[1:0]);
            we_p0    <= is_store_in;
            size_p0  <= load_size_in;
            uns_p0   <= load_unsigned_in;
            rd_p0    <= rd_addr_in;
        end
    end

    load_align u_load_align (
        .rdata       (dbus_rdata_in),
        .addr_lo     (addr_p0[1:0]),
        .size        (size_p0),
        .is_unsigned (uns_p0),
        .data        (aligned)
    );

    // Stage p1: registered load result and trap pulse
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            vld_p1       <= 1'b0;
            load_data_p1 <= '0;
            load_rd_p1   <= '0;
            trap_p1      <= 1'b0;
        end else begin
            vld_p1  <= rsp_take;
            trap_p1 <= trap_hit;
            if (rsp_take) begin
                load_data_p1 <= aligned;
                load_rd_p1   <= rd_p0;
            end
        end
    end

    assign ready_out         = (state_q == IDLE);
    assign stall_out         = (state_q != IDLE);
    assign dbus_req_out      = in_req;
    assign dbus_we_out       = in_req & we_p0;
    assign dbus_addr_out     = in_req ? addr_p0  : '0;
    assign dbus_wdata_out    = in_req ? wdata_p0 : '0;
    assign dbus_be_out       = in_req ? be_p0    : '0;
    assign load_valid_out    = vld_p1;
    assign load_data_out     = load_data_p1;
    assign load_rd_addr_out  = load_rd_p1;
    assign misalign_trap_out = trap_p1;

endmodule
